// File: rtl/cpu_instr_sequencer.sv
// Program sequencer: buffers up to PROG_DEPTH 12-bit words and issues them to a CPU over a
// valid/ready handshake. Optional macro SEQ_LOOP_EN wraps to word 0 at the end of the program.
module cpu_instr_sequencer #(
  parameter int unsigned PROG_DEPTH  = 16,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        load_valid,
  input  logic [11:0] load_word,
  input  logic        start,
  input  logic        clear,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [3:0]  instr_opcode,
  output logic [3:0]  instr_addr,
  output logic [3:0]  instr_data,
  output logic [3:0]  pc,
  output logic [4:0]  prog_count,
  output logic        busy,
  output logic        done,
  output logic        load_full
);

  localparam int unsigned AW = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  pc_q, pc_d;
  logic [4:0]  count_q, count_d;
  logic        valid_q, valid_d;
  logic [11:0] word_q, word_d;
  logic [11:0] prog_q [PROG_DEPTH];

  logic        wr_en;
  logic        full;
  logic [4:0]  nxt;
  logic [11:0] nxt_word;
  logic [11:0] first_word;

  assign full       = (count_q == 5'(PROG_DEPTH));
  assign nxt        = {1'b0, pc_q} + 5'd1;
  assign nxt_word   = prog_q[nxt[AW-1:0]];
  assign first_word = prog_q[0];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    valid_d = valid_q;
    word_d  = word_q;
    wr_en   = 1'b0;
    if (clear) begin
      state_d = StIdle;
      pc_d    = '0;
      count_d = '0;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          // A load in the same cycle as start wins, even when the buffer is full.
          if (load_valid) begin
            if (!full) begin
              wr_en   = 1'b1;
              count_d = count_q + 5'd1;
            end
          end else if (start && (count_q != '0)) begin
            pc_d = '0;
            if (first_word[11:8] == HALT_OPCODE) begin
              state_d = StDone;
            end else begin
              state_d = StRun;
              valid_d = 1'b1;
              word_d  = first_word;
            end
          end
        end
        StRun: begin
          if (valid_q && instr_ready) begin
            if (nxt == count_q) begin
`ifdef SEQ_LOOP_EN
              pc_d = '0;
              if (first_word[11:8] == HALT_OPCODE) begin
                state_d = StDone;
                valid_d = 1'b0;
              end else begin
                word_d = first_word;
              end
`else
              pc_d    = nxt[3:0];
              state_d = StDone;
              valid_d = 1'b0;
`endif
            end else begin
              pc_d = nxt[3:0];
              if (nxt_word[11:8] == HALT_OPCODE) begin
                state_d = StDone;
                valid_d = 1'b0;
              end else begin
                word_d = nxt_word;
              end
            end
          end
        end
        default: begin
          state_d = StIdle;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      word_q  <= '0;
    end else if (ena) begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      valid_q <= valid_d;
      word_q  <= word_d;
    end
  end

  // Buffer contents are unreachable after reset since prog_count is 0, so no reset here.
  always_ff @(posedge clk) begin
    if (ena && wr_en) begin
      prog_q[count_q[AW-1:0]] <= load_word;
    end
  end

  assign instr_valid  = valid_q;
  assign instr_opcode = word_q[11:8];
  assign instr_addr   = word_q[7:4];
  assign instr_data   = word_q[3:0];
  assign pc           = pc_q;
  assign prog_count   = count_q;
  assign busy         = (state_q == StRun);
  assign done         = (state_q == StDone);
  assign load_full    = full;

endmodule

// File: doc/cpu_instr_sequencer.md
CPU_INSTR_SEQUENCER -- requirements
Module: cpu_instr_sequencer

Interface
REQ-001 The block SHALL have parameter PROG_DEPTH, default 16, meaning the program buffer depth in words (power of two, 2..16).
REQ-002 The block SHALL have parameter HALT_OPCODE, default 4'hF, meaning the opcode value that ends a program run; a word with this opcode is never issued.
REQ-003 The block SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 The block SHALL have port ena  input  1  design enable; when low, all state and outputs hold.
REQ-006 The block SHALL have port load_valid  input  1  strobe that appends load_word to the program buffer.
REQ-007 The block SHALL have port load_word  input  12  program word: [11:8] opcode, [7:4] addr, [3:0] data.
REQ-008 The block SHALL have port start  input  1  run request.
REQ-009 The block SHALL have port clear  input  1  flush the program and abort any run.
REQ-010 The block SHALL have port instr_ready  input  1  downstream CPU accepts the presented instruction.
REQ-011 The block SHALL have port instr_valid  output  1  instr_opcode/instr_addr/instr_data are valid.
REQ-012 The block SHALL have ports instr_opcode, instr_addr, instr_data  output  4 each  fields of the word being presented.
REQ-013 The block SHALL have port pc  output  4  index of the word being presented.
REQ-014 The block SHALL have port prog_count  output  5  number of words loaded.
REQ-015 The block SHALL have port busy  output  1  high in RUN.
REQ-016 The block SHALL have port done  output  1  high in DONE.
REQ-017 The block SHALL have port load_full  output  1  high when prog_count == PROG_DEPTH.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-019 In IDLE or DONE, load_valid with !load_full SHALL write prog[prog_count] and increment prog_count; when load_full is high, load_valid SHALL be ignored with no change.
REQ-020 If load_valid and start occur in the same cycle, the load SHALL take effect and start SHALL be ignored.
REQ-021 In IDLE or DONE, start with prog_count > 0 SHALL set pc to 0 and enter RUN; start with prog_count == 0 SHALL be ignored.
REQ-022 On RUN entry, the word at pc SHALL be examined; if its opcode is not HALT_OPCODE, it SHALL be presented with instr_valid = 1 on the first RUN cycle (latency one cycle from start).
REQ-023 Presented fields and instr_valid SHALL stay stable until the cycle in which instr_valid && instr_ready.
REQ-024 On a handshake, pc SHALL increment by one; with instr_ready held high, the block SHALL issue one instruction per cycle.
REQ-025 If the incremented pc equals prog_count, or the word at that pc has opcode HALT_OPCODE, the block SHALL deassert instr_valid in the next cycle and enter DONE.
REQ-026 If word 0 is a halt word, start SHALL lead to DONE with no instr_valid pulse.
REQ-027 start and load_valid during RUN SHALL be ignored.
REQ-028 clear in any state SHALL set prog_count and pc to 0, deassert instr_valid in the next cycle and enter IDLE, and clear SHALL take priority over all other inputs.
REQ-029 While ena is low, state, pc, prog_count and outputs SHALL hold, and instr_ready SHALL be ignored.

Reset
REQ-030 rst_n low SHALL asynchronously force IDLE, with pc = 0, prog_count = 0, instr_valid = 0, busy = 0, done = 0, load_full = 0 and instruction fields = 0.
REQ-031 Program buffer contents need not be reset; they are unreachable because prog_count = 0.
REQ-032 A reset asserted mid-RUN SHALL abort the run with no further instruction issued.

Configuration
REQ-033 When SEQ_LOOP_EN is defined, reaching pc == prog_count SHALL wrap pc to 0 and remain in RUN; a halt word or clear still ends the run.
REQ-034 When SEQ_LOOP_EN is undefined, reaching pc == prog_count SHALL enter DONE per REQ-025.

Verification
REQ-035 Load 3 words (0x3_2_0, 0x0_0_5, 0x2_4_0), start, instr_ready=1 -> instr_valid for exactly 3 cycles, opcodes 3,0,2, pc 0,1,2, then done=1.
REQ-036 Same program with instr_ready low for 2 cycles on word 1 -> word 1 held stable for 3 cycles, no skip, no duplicate.
REQ-037 Load 0x0_0_1, 0xF_0_0, 0x1_0_1; start -> only word 0 is issued, then DONE; with SEQ_LOOP_EN and no halt word, the sequence repeats 0,1,2,0,...
REQ-038 Load 16 words then a 17th -> load_full=1, prog_count stays 16, and word 15 is unchanged.
REQ-039 clear asserted during RUN at pc=1 -> instr_valid=0 next cycle, IDLE, prog_count=0, and a subsequent start is ignored.
REQ-040 rst_n asserted mid-run and asynchronously between edges -> all outputs 0 immediately; ena low mid-run -> pc and instr fields frozen.
